// File: rtl/edge_bbox_pkg.sv
// Shared constants and helpers for edge_bbox, derived from global.vh.
`include "global.vh"

package edge_bbox_pkg;

   localparam int PIX_W           = `PIXEL_SIZE;
   localparam int COORD_W_DEFAULT = `COORD_SIZE;

   localparam logic [PIX_W-1:0] PIX_EDGE = `EDGE_ON;
   localparam logic [PIX_W-1:0] PIX_OFF  = '0;

   // Axis indices for the per-axis min/max accumulators.
   localparam int AXIS_X  = 0;
   localparam int AXIS_Y  = 1;
   localparam int N_AXIS  = 2;

   function automatic logic above_thr(input logic [PIX_W-1:0] mag,
                                      input logic [PIX_W-1:0] thr);
      return mag > thr;
   endfunction

endpackage

// File: rtl/edge_bbox_raster_counter.sv
// raster_counter: pixel/line position tracker driven by en/hsync/vsync, saturating.
module raster_counter #(
   parameter int COORD_W = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_en,
   input  logic               i_hsync,
   input  logic               i_vsync,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y
);

   localparam logic [COORD_W-1:0] C_MAX = '1;
   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;

   // vsync dominates hsync, which dominates the pixel step.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_vsync) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_hsync) begin
         r_x <= '0;
         if (r_y != C_MAX) r_y <= r_y + C_ONE;
      end else if (i_en && (r_x != C_MAX)) begin
         r_x <= r_x + C_ONE;
      end
   end

   assign o_x = r_x;
   assign o_y = r_y;

endmodule

// File: rtl/global.vh
// Project-wide pixel and coordinate constants shared by the edge pipeline.
`ifndef GLOBAL_VH
`define GLOBAL_VH

`define PIXEL_SIZE 8
`define COORD_SIZE 11
`define EDGE_ON {`PIXEL_SIZE{1'b1}}

`endif

// File: rtl/edge_bbox.sv
// edge_bbox: thresholds gradient magnitude into a mask and reports the per-frame
// edge bounding box at vsync. Define BBOX_COUNT_EN to add the edge_count output.
module edge_bbox
   import edge_bbox_pkg::*;
#(
   parameter int width     = 1,
   parameter int height    = 1,
   parameter int THRESHOLD = 64,
   parameter int COORD_W   = COORD_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 hsync,
   input  logic                 vsync,
   input  logic [PIX_W-1:0]     data,
   output logic [PIX_W-1:0]     out,
   output logic                 bbox_valid,
   output logic                 found,
   output logic [COORD_W-1:0]   x_min,
   output logic [COORD_W-1:0]   x_max,
   output logic [COORD_W-1:0]   y_min,
   output logic [COORD_W-1:0]   y_max
`ifdef BBOX_COUNT_EN
   ,
   output logic [2*COORD_W-1:0] edge_count
`endif
);

   localparam logic [COORD_W-1:0] W_LIM = COORD_W'(width);
   localparam logic [COORD_W-1:0] H_LIM = COORD_W'(height);
   localparam logic [PIX_W-1:0]   THR   = PIX_W'(THRESHOLD);

   logic [COORD_W-1:0] w_x;
   logic [COORD_W-1:0] w_y;
   logic               w_hot;
   logic               w_edge;
   logic               w_any_next;
   logic [COORD_W-1:0] w_pos      [N_AXIS];
   logic [COORD_W-1:0] w_min_next [N_AXIS];
   logic [COORD_W-1:0] w_max_next [N_AXIS];

   logic [PIX_W-1:0]   r_out;
   logic               r_valid;
   logic               r_found;
   logic               r_acc_any;
   logic [COORD_W-1:0] r_acc_min [N_AXIS];
   logic [COORD_W-1:0] r_acc_max [N_AXIS];
   logic [COORD_W-1:0] r_rep_min [N_AXIS];
   logic [COORD_W-1:0] r_rep_max [N_AXIS];

   raster_counter #(
      .COORD_W (COORD_W)
   ) u_raster (
      .clk     (clk),
      .reset   (reset),
      .i_en    (en),
      .i_hsync (hsync),
      .i_vsync (vsync),
      .o_x     (w_x),
      .o_y     (w_y)
   );

   // Counters still show the pre-update position this cycle, so the pixel is
   // judged at its own coordinates even when hsync/vsync coincide.
   assign w_hot      = en && above_thr(data, THR);
   assign w_edge     = w_hot && (w_x < W_LIM) && (w_y < H_LIM);
   assign w_any_next = r_acc_any | w_edge;

   assign w_pos[AXIS_X] = w_x;
   assign w_pos[AXIS_Y] = w_y;

   generate
      for (genvar gi = 0; gi < N_AXIS; gi++) begin : g_axis
         assign w_min_next[gi] = (w_edge && (w_pos[gi] < r_acc_min[gi])) ? w_pos[gi] : r_acc_min[gi];
         assign w_max_next[gi] = (w_edge && (w_pos[gi] > r_acc_max[gi])) ? w_pos[gi] : r_acc_max[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out     <= PIX_OFF;
         r_valid   <= 1'b0;
         r_found   <= 1'b0;
         r_acc_any <= 1'b0;
         for (int i = 0; i < N_AXIS; i++) begin
            r_acc_min[i] <= '1;
            r_acc_max[i] <= '0;
            r_rep_min[i] <= '0;
            r_rep_max[i] <= '0;
         end
      end else begin
         r_out   <= w_hot ? PIX_EDGE : PIX_OFF;
         r_valid <= vsync;
         if (vsync) begin
            // An empty frame reports zeros rather than the all-ones sentinel.
            r_found   <= w_any_next;
            r_acc_any <= 1'b0;
            for (int i = 0; i < N_AXIS; i++) begin
               r_rep_min[i] <= w_any_next ? w_min_next[i] : '0;
               r_rep_max[i] <= w_any_next ? w_max_next[i] : '0;
               r_acc_min[i] <= '1;
               r_acc_max[i] <= '0;
            end
         end else begin
            r_acc_any <= w_any_next;
            for (int i = 0; i < N_AXIS; i++) begin
               r_acc_min[i] <= w_min_next[i];
               r_acc_max[i] <= w_max_next[i];
            end
         end
      end
   end

`ifdef BBOX_COUNT_EN
   localparam int              CNT_W   = 2 * COORD_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_acc_cnt;
   logic [CNT_W-1:0] r_rep_cnt;
   logic [CNT_W-1:0] w_cnt_next;

   assign w_cnt_next = (w_edge && (r_acc_cnt != CNT_MAX)) ? r_acc_cnt + CNT_ONE : r_acc_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc_cnt <= '0;
         r_rep_cnt <= '0;
      end else if (vsync) begin
         r_rep_cnt <= w_cnt_next;
         r_acc_cnt <= '0;
      end else begin
         r_acc_cnt <= w_cnt_next;
      end
   end

   assign edge_count = r_rep_cnt;
`endif

   assign out        = r_out;
   assign bbox_valid = r_valid;
   assign found      = r_found;
   assign x_min      = r_rep_min[AXIS_X];
   assign x_max      = r_rep_max[AXIS_X];
   assign y_min      = r_rep_min[AXIS_Y];
   assign y_max      = r_rep_max[AXIS_Y];

endmodule

// File: tb/tb_edge_bbox.sv
// Directed and randomized frames for edge_bbox checked against a raster/edge-list model.
module tb_edge_bbox;

   localparam int W    = 8;
   localparam int H    = 4;
   localparam int THR  = 64;
   localparam int CW   = 11;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          hsync;
   logic          vsync;
   logic [7:0]    data;
   logic [7:0]    out;
   logic          bbox_valid;
   logic          found;
   logic [CW-1:0] x_min;
   logic [CW-1:0] x_max;
   logic [CW-1:0] y_min;
   logic [CW-1:0] y_max;
`ifdef BBOX_COUNT_EN
   logic [2*CW-1:0] edge_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Model: current raster position, list of edge pixels this frame, last report.
   int m_x, m_y;
   int q_x[$];
   int q_y[$];
   int e_out, e_valid, e_found, e_xmin, e_xmax, e_ymin, e_ymax, e_cnt;

   always #5 clk = ~clk;

   edge_bbox #(
      .width     (W),
      .height    (H),
      .THRESHOLD (THR),
      .COORD_W   (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .hsync      (hsync),
      .vsync      (vsync),
      .data       (data),
      .out        (out),
      .bbox_valid (bbox_valid),
      .found      (found),
      .x_min      (x_min),
      .x_max      (x_max),
      .y_min      (y_min),
      .y_max      (y_max)
`ifdef BBOX_COUNT_EN
      ,
      .edge_count (edge_count)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_report();
      if (q_x.size() == 0) begin
         e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
      end else begin
         e_found = 1;
         e_xmin = q_x[0]; e_xmax = q_x[0]; e_ymin = q_y[0]; e_ymax = q_y[0];
         foreach (q_x[i]) begin
            if (q_x[i] < e_xmin) e_xmin = q_x[i];
            if (q_x[i] > e_xmax) e_xmax = q_x[i];
            if (q_y[i] < e_ymin) e_ymin = q_y[i];
            if (q_y[i] > e_ymax) e_ymax = q_y[i];
         end
         e_cnt = q_x.size();
      end
   endtask

   task automatic cycle(input bit rs, input bit e, input bit hs, input bit vs, input logic [7:0] d);
      reset = rs; en = e; hsync = hs; vsync = vs; data = d;
      @(posedge clk);
      #1;
      if (rs) begin
         q_x.delete(); q_y.delete();
         m_x = 0; m_y = 0;
         e_out = 0; e_valid = 0;
         e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
      end else begin
         e_out = (e && int'(d) > THR) ? 255 : 0;
         if (e) begin
            if (int'(d) > THR && m_x < W && m_y < H) begin
               q_x.push_back(m_x);
               q_y.push_back(m_y);
            end
            if (m_x < CMAX) m_x++;
         end
         if (hs) begin
            m_x = 0;
            if (m_y < CMAX) m_y++;
         end
         e_valid = vs ? 1 : 0;
         if (vs) begin
            model_report();
            q_x.delete(); q_y.delete();
            m_x = 0; m_y = 0;
         end
      end
      chk("out",        int'(out),        e_out);
      chk("bbox_valid", int'(bbox_valid), e_valid);
      chk("found",      int'(found),      e_found);
      chk("x_min",      int'(x_min),      e_xmin);
      chk("x_max",      int'(x_max),      e_xmax);
      chk("y_min",      int'(y_min),      e_ymin);
      chk("y_max",      int'(y_max),      e_ymax);
`ifdef BBOX_COUNT_EN
      chk("edge_count", int'(edge_count), e_cnt);
`endif
   endtask

   task automatic pix(input logic [7:0] d);
      cycle(0, 1, 0, 0, d);
   endtask

   task automatic eol();
      cycle(0, 0, 1, 0, 8'd0);
   endtask

   task automatic eof();
      cycle(0, 0, 0, 1, 8'd0);
   endtask

   task automatic exp_box(input string tag, input int f, input int x0, input int x1,
                          input int y0, input int y1, input int c);
      chk({tag, "_valid"}, int'(bbox_valid), 1);
      chk({tag, "_found"}, int'(found), f);
      chk({tag, "_xmin"},  int'(x_min), x0);
      chk({tag, "_xmax"},  int'(x_max), x1);
      chk({tag, "_ymin"},  int'(y_min), y0);
      chk({tag, "_ymax"},  int'(y_max), y1);
`ifdef BBOX_COUNT_EN
      chk({tag, "_count"}, int'(edge_count), c);
`else
      if (c < 0) chk({tag, "_count"}, c, 0);
`endif
   endtask

   initial begin
      logic [7:0] d;
      int rows, len;

      reset = 1'b1; en = 1'b0; hsync = 1'b0; vsync = 1'b0; data = 8'd0;

      // Reset, then idle: everything stays at zero and no strobe appears.
      cycle(1, 0, 0, 0, 8'd0);
      cycle(1, 0, 0, 0, 8'd0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 8'd0);
      chk("idle_valid", int'(bbox_valid), 0);
      chk("idle_out",   int'(out), 0);

      // Single edge pixel of 100 at (3,2).
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) pix((x == 3 && y == 2) ? 8'd100 : 8'd0);
         eol();
      end
      eof();
      exp_box("single", 1, 3, 3, 2, 2, 1);
      cycle(0, 0, 0, 0, 8'd0);
      chk("single_strobe_once", int'(bbox_valid), 0);
      chk("single_hold_xmin",   int'(x_min), 3);

      // 200 at (1,0) and (6,3); a pixel equal to the threshold is not an edge.
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            if ((x == 1 && y == 0) || (x == 6 && y == 3)) d = 8'd200;
            else if (x == 4 && y == 1) d = 8'd64;
            else d = 8'd0;
            pix(d);
            if (x == 4 && y == 1) chk("thr_equal_out", int'(out), 0);
         end
         eol();
      end
      eof();
      exp_box("pair", 1, 1, 6, 0, 3, 2);

      // Empty frame.
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) pix(8'd0);
         eol();
      end
      eof();
      exp_box("empty", 0, 0, 0, 0, 0, 0);

      // Hot pixels outside the active area drive out but are never edges.
      for (int x = 0; x < W + 3; x++) pix((x >= W) ? 8'd255 : 8'd0);
      chk("outside_out", int'(out), 255);
      eol();
      eof();
      exp_box("outside", 0, 0, 0, 0, 0, 0);

      // Edge pixel at (7,3) with en, hsync and vsync together.
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W - 1; x++) pix(8'd0);
         if (y < H - 1) begin
            pix(8'd0);
            eol();
         end else begin
            cycle(0, 1, 1, 1, 8'd150);
         end
      end
      exp_box("combo", 1, 7, 7, 3, 3, 1);
      pix(8'd90);
      eof();
      exp_box("after_combo", 1, 0, 0, 0, 0, 1);

      // Back-to-back vsync: second strobe reports an empty frame.
      pix(8'd0); pix(8'd99);
      eof();
      exp_box("b2b_first", 1, 1, 1, 0, 0, 1);
      eof();
      exp_box("b2b_second", 0, 0, 0, 0, 0, 0);

      // Reset mid-frame after an edge at (2,1), then a clean frame with only (5,0).
      for (int x = 0; x < W; x++) pix(8'd0);
      eol();
      pix(8'd0); pix(8'd0); pix(8'd120);
      cycle(1, 0, 0, 0, 8'd0);
      chk("midrst_valid", int'(bbox_valid), 0);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) pix((x == 5 && y == 0) ? 8'd100 : 8'd0);
         eol();
      end
      eof();
      exp_box("post_reset", 1, 5, 5, 0, 0, 1);

      // Randomized frames with gaps, ragged lines and coincident sync pulses.
      for (int f = 0; f < 30; f++) begin
         rows = int'($urandom_range(2, 6));
         for (int r = 0; r < rows; r++) begin
            len = int'($urandom_range(4, 11));
            for (int p = 0; p < len; p++) begin
               if ($urandom_range(0, 9) < 2) d = 8'($urandom_range(65, 255));
               else d = 8'($urandom_range(0, 70));
               cycle(0, ($urandom_range(0, 99) < 85), 0, 0, d);
            end
            if ($urandom_range(0, 3) == 0) cycle(0, 1, 1, 0, 8'($urandom_range(0, 255)));
            else eol();
         end
         case ($urandom_range(0, 2))
            0: eof();
            1: cycle(0, 1, 0, 1, 8'($urandom_range(60, 255)));
            default: cycle(0, 1, 1, 1, 8'($urandom_range(60, 255)));
         endcase
         if ($urandom_range(0, 4) == 0) eof();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
